// File: rtl/sram_rr_scheduler.sv
// Four-port (W0, W1, R0, R1) round-robin SRAM request scheduler with an in-order
// read tag FIFO that steers returned read data back to the requesting read port.
module sram_rr_scheduler #(
  parameter int ADDR_WIDTH = 19,
  parameter int DATA_WIDTH = 32,
  parameter int MASK_WIDTH = 4,
  parameter int TAG_DEPTH  = 4
) (
  input  logic                  sram_clock,
  input  logic                  reset_n,
  input  logic                  w0_valid,
  output logic                  w0_ready,
  input  logic [ADDR_WIDTH-1:0] w0_addr,
  input  logic [DATA_WIDTH-1:0] w0_data,
  input  logic [MASK_WIDTH-1:0] w0_mask,
  input  logic                  w1_valid,
  output logic                  w1_ready,
  input  logic [ADDR_WIDTH-1:0] w1_addr,
  input  logic [DATA_WIDTH-1:0] w1_data,
  input  logic [MASK_WIDTH-1:0] w1_mask,
  input  logic                  r0_valid,
  output logic                  r0_ready,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  output logic [DATA_WIDTH-1:0] r0_dout,
  output logic                  r0_dout_valid,
  input  logic                  r1_valid,
  output logic                  r1_ready,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  output logic [DATA_WIDTH-1:0] r1_dout,
  output logic                  r1_dout_valid,
  input  logic                  sram_ready,
  output logic                  sram_addr_valid,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_data_in,
  output logic [MASK_WIDTH-1:0] sram_write_mask,
  input  logic [DATA_WIDTH-1:0] sram_data_out,
  input  logic                  sram_data_out_valid,
  output logic [2:0]            state,
  output logic                  tag_error
);
  localparam int PW = $clog2(TAG_DEPTH);
  localparam logic [PW:0]   DEPTH_C = (PW+1)'(TAG_DEPTH);
  localparam logic [PW:0]   CNT_ONE = 1;
  localparam logic [PW-1:0] PTR_ONE = 1;
  localparam logic [1:0] P_W0 = 2'd0, P_W1 = 2'd1, P_R0 = 2'd2, P_R1 = 2'd3;

  // Handshake: a request transfers in the cycle its *_valid and *_ready are both
  // high; ready is combinational, goes to the single arbitration winner only, and
  // never depends on anything but current valids, sram_ready and internal state.
  logic [1:0]            last_grant_q, port_q;
  logic [PW:0]           count_q;
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [TAG_DEPTH-1:0]  tag_mem_q;
  logic                  addr_valid_q, err_q, r0_dv_q, r1_dv_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q, r0_dout_q, r1_dout_q;
  logic [MASK_WIDTH-1:0] mask_q;

  logic [3:0]            eligible;
  logic [1:0]            cand, grant_port;
  logic                  grant_any, push, pop, pop_tag;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [MASK_WIDTH-1:0] sel_mask;

  // Read eligibility uses the count before this cycle's pop.
  assign eligible = {r1_valid && (count_q < DEPTH_C), r0_valid && (count_q < DEPTH_C),
                     w1_valid, w0_valid};

  always_comb begin
    grant_any  = 1'b0;
    grant_port = last_grant_q;
    cand       = last_grant_q;
    for (int i = 1; i <= 4; i++) begin
      cand = last_grant_q + 2'(i);
      if (sram_ready && !grant_any && eligible[cand]) begin
        grant_any  = 1'b1;
        grant_port = cand;
      end
    end
  end

  assign w0_ready = grant_any && (grant_port == P_W0);
  assign w1_ready = grant_any && (grant_port == P_W1);
  assign r0_ready = grant_any && (grant_port == P_R0);
  assign r1_ready = grant_any && (grant_port == P_R1);

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    sel_mask = '0;
    case (grant_port)
      P_W0: begin
        sel_addr = w0_addr;
        sel_data = w0_data;
        sel_mask = (w0_mask == '0) ? '1 : w0_mask;
      end
      P_W1: begin
        sel_addr = w1_addr;
        sel_data = w1_data;
        sel_mask = (w1_mask == '0) ? '1 : w1_mask;
      end
      P_R0:    sel_addr = r0_addr;
      default: sel_addr = r1_addr;
    endcase
  end

  assign push    = r0_ready || r1_ready;
  assign pop     = sram_data_out_valid && (count_q != '0);
  assign pop_tag = tag_mem_q[rd_ptr_q];

  always_ff @(posedge sram_clock or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= P_R1;
      port_q       <= '0;
      addr_valid_q <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      mask_q       <= '0;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      tag_mem_q    <= '0;
      r0_dv_q      <= 1'b0;
      r1_dv_q      <= 1'b0;
      r0_dout_q    <= '0;
      r1_dout_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      addr_valid_q <= grant_any;
      if (grant_any) begin
        addr_q       <= sel_addr;
        data_q       <= sel_data;
        mask_q       <= sel_mask;
        port_q       <= grant_port;
        last_grant_q <= grant_port;
      end else begin
        addr_q <= '0;
        data_q <= '0;
        mask_q <= '0;
      end
      // Tag entry holds grant_port[0]: 0 routes the return to R0, 1 to R1.
      if (push) begin
        tag_mem_q[wr_ptr_q] <= grant_port[0];
        wr_ptr_q            <= wr_ptr_q + PTR_ONE;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      if (push && !pop)      count_q <= count_q + CNT_ONE;
      else if (pop && !push) count_q <= count_q - CNT_ONE;
      r0_dv_q <= pop && !pop_tag;
      r1_dv_q <= pop && pop_tag;
      if (pop && !pop_tag) r0_dout_q <= sram_data_out;
      if (pop && pop_tag)  r1_dout_q <= sram_data_out;
      if (sram_data_out_valid && (count_q == '0)) err_q <= 1'b1;
    end
  end

  assign sram_addr_valid = addr_valid_q;
  assign sram_addr       = addr_q;
  assign sram_data_in    = data_q;
  assign sram_write_mask = mask_q;
  assign r0_dout         = r0_dout_q;
  assign r1_dout         = r1_dout_q;
  assign r0_dout_valid   = r0_dv_q;
  assign r1_dout_valid   = r1_dv_q;
  assign state           = {addr_valid_q, port_q};
  assign tag_error       = err_q;
endmodule

// File: tb/tb_sram_rr_scheduler.sv
// Directed bench for sram_rr_scheduler: a per-cycle vector table for arbitration,
// tag-FIFO masking, return routing and stall, plus a hand-written reset sequence.
module tb_sram_rr_scheduler;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        w0_valid, w1_valid, r0_valid, r1_valid;
  logic        w0_ready, w1_ready, r0_ready, r1_ready;
  logic [18:0] w0_addr, w1_addr, r0_addr, r1_addr;
  logic [31:0] w0_data, w1_data;
  logic [3:0]  w0_mask, w1_mask;
  logic [31:0] r0_dout, r1_dout;
  logic        r0_dout_valid, r1_dout_valid;
  logic        sram_ready, sram_addr_valid, sram_data_out_valid;
  logic [18:0] sram_addr;
  logic [31:0] sram_data_in, sram_data_out;
  logic [3:0]  sram_write_mask;
  logic [2:0]  state;
  logic        tag_error;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sram_rr_scheduler dut (
    .sram_clock(clk), .reset_n(reset_n),
    .w0_valid(w0_valid), .w0_ready(w0_ready), .w0_addr(w0_addr), .w0_data(w0_data), .w0_mask(w0_mask),
    .w1_valid(w1_valid), .w1_ready(w1_ready), .w1_addr(w1_addr), .w1_data(w1_data), .w1_mask(w1_mask),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_addr(r0_addr), .r0_dout(r0_dout),
    .r0_dout_valid(r0_dout_valid),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_addr(r1_addr), .r1_dout(r1_dout),
    .r1_dout_valid(r1_dout_valid),
    .sram_ready(sram_ready), .sram_addr_valid(sram_addr_valid), .sram_addr(sram_addr),
    .sram_data_in(sram_data_in), .sram_write_mask(sram_write_mask),
    .sram_data_out(sram_data_out), .sram_data_out_valid(sram_data_out_valid),
    .state(state), .tag_error(tag_error)
  );

  typedef struct {
    logic [3:0]  req;     // {r1,r0,w1,w0} valid
    logic        srdy;
    logic        rv;
    logic [31:0] rd;
    logic [3:0]  e_rdy;   // {r1,r0,w1,w0} ready this cycle
    logic [2:0]  e_st;
    logic [1:0]  e_dv;    // {r1,r0} dout_valid
    logic [31:0] e_do;
    logic        e_err;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic [3:0] req, input logic srdy, input logic rv, input logic [31:0] rd,
                     input logic [3:0] e_rdy, input logic [2:0] e_st, input logic [1:0] e_dv,
                     input logic [31:0] e_do, input logic e_err);
    vq.push_back('{req, srdy, rv, rd, e_rdy, e_st, e_dv, e_do, e_err});
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected issue fields for each port, given the fixed request payloads below.
  function automatic logic [18:0] exp_addr(input logic [1:0] p);
    case (p)
      2'd0: return 19'h10;
      2'd1: return 19'h20;
      2'd2: return 19'h30;
      default: return 19'h40;
    endcase
  endfunction
  function automatic logic [31:0] exp_data(input logic [1:0] p);
    case (p)
      2'd0: return 32'hDEADBEEF;
      2'd1: return 32'h12345678;
      default: return 32'h0;
    endcase
  endfunction
  function automatic logic [3:0] exp_mask(input logic [1:0] p);
    case (p)
      2'd0: return 4'hF;
      2'd1: return 4'h3;
      default: return 4'h0;
    endcase
  endfunction

  task automatic drive(input logic [3:0] req, input logic srdy, input logic rv, input logic [31:0] rd);
    {r1_valid, r0_valid, w1_valid, w0_valid} = req;
    sram_ready          = srdy;
    sram_data_out_valid = rv;
    sram_data_out       = rd;
  endtask

  task automatic apply(input int idx, input vec_t v);
    @(negedge clk);
    drive(v.req, v.srdy, v.rv, v.rd);
    #1;
    chk($sformatf("v%0d ready", idx), {28'd0, r1_ready, r0_ready, w1_ready, w0_ready}, {28'd0, v.e_rdy});
    chk($sformatf("v%0d state", idx), {29'd0, state}, {29'd0, v.e_st});
    chk($sformatf("v%0d dout_valid", idx), {30'd0, r1_dout_valid, r0_dout_valid}, {30'd0, v.e_dv});
    chk($sformatf("v%0d tag_error", idx), {31'd0, tag_error}, {31'd0, v.e_err});
    if (v.e_st[2]) begin
      chk($sformatf("v%0d sram_addr", idx), {13'd0, sram_addr}, {13'd0, exp_addr(v.e_st[1:0])});
      chk($sformatf("v%0d sram_data_in", idx), sram_data_in, exp_data(v.e_st[1:0]));
      chk($sformatf("v%0d sram_write_mask", idx), {28'd0, sram_write_mask}, {28'd0, exp_mask(v.e_st[1:0])});
    end
    if (v.e_dv[0]) chk($sformatf("v%0d r0_dout", idx), r0_dout, v.e_do);
    if (v.e_dv[1]) chk($sformatf("v%0d r1_dout", idx), r1_dout, v.e_do);
  endtask

  initial begin
    reset_n = 1'b0;
    drive(4'b0000, 1'b0, 1'b0, 32'h0);
    w0_addr = 19'h10; w0_data = 32'hDEADBEEF; w0_mask = 4'h0;
    w1_addr = 19'h20; w1_data = 32'h12345678; w1_mask = 4'h3;
    r0_addr = 19'h30; r1_addr = 19'h40;

    // All four valid: W0,W1,R0,R1 twice, then four tags outstanding mask the reads.
    add(4'b1111, 1, 0, 0, 4'b0001, 3'b000, 2'b00, 0, 0);
    add(4'b1111, 1, 0, 0, 4'b0010, 3'b100, 2'b00, 0, 0);
    add(4'b1111, 1, 0, 0, 4'b0100, 3'b101, 2'b00, 0, 0);
    add(4'b1111, 1, 0, 0, 4'b1000, 3'b110, 2'b00, 0, 0);
    add(4'b1111, 1, 0, 0, 4'b0001, 3'b111, 2'b00, 0, 0);
    add(4'b1111, 1, 0, 0, 4'b0010, 3'b100, 2'b00, 0, 0);
    add(4'b1111, 1, 0, 0, 4'b0100, 3'b101, 2'b00, 0, 0);
    add(4'b1111, 1, 0, 0, 4'b1000, 3'b110, 2'b00, 0, 0);
    add(4'b1111, 1, 0, 0, 4'b0001, 3'b111, 2'b00, 0, 0);
    add(4'b1111, 1, 0, 0, 4'b0010, 3'b100, 2'b00, 0, 0);
    add(4'b1111, 1, 0, 0, 4'b0001, 3'b101, 2'b00, 0, 0);
    add(4'b1111, 1, 0, 0, 4'b0010, 3'b100, 2'b00, 0, 0);
    // FIFO full: only W1 and R0 valid; R0 eligible again the cycle after a return.
    add(4'b0110, 1, 0, 0,            4'b0010, 3'b101, 2'b00, 0, 0);
    add(4'b0110, 1, 1, 32'hAAAA0001, 4'b0010, 3'b101, 2'b00, 0, 0);
    add(4'b0110, 1, 0, 0,            4'b0100, 3'b101, 2'b01, 32'hAAAA0001, 0);
    add(4'b0110, 1, 0, 0,            4'b0010, 3'b110, 2'b00, 0, 0);
    // Drain the four outstanding tags in issue order R1,R0,R1,R0.
    add(4'b0000, 1, 1, 32'hBBBB0002, 4'b0000, 3'b101, 2'b00, 0, 0);
    add(4'b0000, 1, 1, 32'hCCCC0003, 4'b0000, 3'b001, 2'b10, 32'hBBBB0002, 0);
    add(4'b0000, 1, 1, 32'hDDDD0004, 4'b0000, 3'b001, 2'b01, 32'hCCCC0003, 0);
    add(4'b0000, 1, 1, 32'hEEEE0005, 4'b0000, 3'b001, 2'b10, 32'hDDDD0004, 0);
    add(4'b0000, 1, 0, 0,            4'b0000, 3'b001, 2'b01, 32'hEEEE0005, 0);
    // sram_ready low for 5 cycles; resume at last_grant+1 (R0).
    for (int i = 0; i < 5; i++) add(4'b1111, 0, 0, 0, 4'b0000, 3'b001, 2'b00, 0, 0);
    add(4'b1111, 1, 0, 0, 4'b0100, 3'b001, 2'b00, 0, 0);
    add(4'b1111, 1, 0, 0, 4'b1000, 3'b110, 2'b00, 0, 0);
    add(4'b1111, 1, 0, 0, 4'b0001, 3'b111, 2'b00, 0, 0);
    add(4'b0000, 1, 0, 0, 4'b0000, 3'b100, 2'b00, 0, 0);
    // Returns for R0 then R1, then a stray return with the FIFO empty.
    add(4'b0000, 1, 1, 32'h0000AAAA, 4'b0000, 3'b000, 2'b00, 0, 0);
    add(4'b0000, 1, 1, 32'h0000BBBB, 4'b0000, 3'b000, 2'b01, 32'h0000AAAA, 0);
    add(4'b0000, 1, 1, 32'h00000099, 4'b0000, 3'b000, 2'b10, 32'h0000BBBB, 0);
    add(4'b0000, 1, 0, 0,            4'b0000, 3'b000, 2'b00, 0, 1);
    add(4'b0000, 1, 0, 0,            4'b0000, 3'b000, 2'b00, 0, 1);

    repeat (2) @(negedge clk);
    chk("reset state", {29'd0, state}, 32'd0);
    chk("reset addr_valid", {31'd0, sram_addr_valid}, 32'd0);
    chk("reset tag_error", {31'd0, tag_error}, 32'd0);
    reset_n = 1'b1;

    foreach (vq[i]) apply(i, vq[i]);

    // Mid-burst reset with reads in flight, then W0 first and a stray return.
    @(negedge clk); drive(4'b1111, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    @(negedge clk); reset_n = 1'b0;
    #1;
    chk("rst state", {29'd0, state}, 32'd0);
    chk("rst addr_valid", {31'd0, sram_addr_valid}, 32'd0);
    chk("rst sram_addr", {13'd0, sram_addr}, 32'd0);
    chk("rst tag_error", {31'd0, tag_error}, 32'd0);
    chk("rst dout", {r1_dout_valid, r0_dout_valid, 30'd0} | r0_dout | r1_dout, 32'd0);
    @(negedge clk); reset_n = 1'b1;
    #1;
    chk("post-rst ready", {28'd0, r1_ready, r0_ready, w1_ready, w0_ready}, 32'b0001);
    @(negedge clk); drive(4'b0000, 1'b1, 1'b1, 32'h5555);
    #1;
    chk("post-rst state", {29'd0, state}, 32'b100);
    chk("post-rst sram_addr", {13'd0, sram_addr}, 32'h10);
    chk("post-rst data_in", sram_data_in, 32'hDEADBEEF);
    chk("post-rst mask", {28'd0, sram_write_mask}, 32'hF);
    @(negedge clk); drive(4'b0000, 1'b1, 1'b0, 32'h0);
    #1;
    chk("stray tag_error", {31'd0, tag_error}, 32'd1);
    chk("stray dout_valid", {30'd0, r1_dout_valid, r0_dout_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
